uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
// PURPOSE
//   8N1 UART receiver: synchronises the asynchronous serial line, qualifies
//   the start bit, samples 8 data bits (LSB first) at bit centre and checks the
//   stop bit. Receive end of the board UART link; pairs with the UART
//   transmitter on the same CLK_FREQ/BAUD_RATE setup for loopback tests.
// PARAMETERS
//   CLK_FREQ      1_152_000  system clock frequency, Hz
//   BAUD_RATE     115_200    line rate, bit/s
//   CLKS_PER_BIT  CLK_FREQ/BAUD_RATE (=10)  derived, localparam; must be >= 4
// PORTS
//   CLK        in   1  system clock, all logic on rising edge
//   RST        in   1  asynchronous, active-low reset
//   Rxd        in   1  serial input, idle high, asynchronous to CLK
//   Dout       out  8  last correctly framed byte; held until next good byte
//   Valid      out  1  1-cycle pulse: Dout updated this cycle
//   Frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   Busy       out  1  high whenever FSM is not IDLE
// BEHAVIOUR
//   Reset (RST=0, async): state=IDLE, Dout=8'h00, Valid=0, Frame_err=0,
//     Busy=0, counters=0, shift reg=0, both sync FFs=1 (idle line level).
//   Input: 2-FF synchroniser; FSM sees rx_s = Rxd delayed 2 CLK.
//   clk_cnt: width $clog2(CLKS_PER_BIT); bit_idx: 3 bits, 0..7.
//   FSM:
//   - IDLE: clk_cnt=0, bit_idx=0. rx_s==0 -> START.
//   - START: clk_cnt++ each cycle. At clk_cnt==CLKS_PER_BIT/2-1 (start-bit
//     centre): rx_s==0 -> DATA, clk_cnt=0; rx_s==1 -> IDLE (glitch, no flag).
//   - DATA: clk_cnt++; at clk_cnt==CLKS_PER_BIT-1: shift reg
//     <= {rx_s, shift[7:1]}, clk_cnt=0; bit_idx==7 -> STOP, bit_idx=0,
//     else bit_idx++.
//   - STOP: clk_cnt++; at clk_cnt==CLKS_PER_BIT-1: rx_s==1 -> Dout<=shift,
//     Valid=1 that cycle; rx_s==0 -> Frame_err=1 that cycle, Dout unchanged.
//     Either way -> IDLE, clk_cnt=0.
//   - Valid/Frame_err registered, never both high, never high >1 cycle.
//   Latency: Valid rises (2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT) CLK after the
//     Rxd falling edge, +-1 (=97 CLK at defaults), i.e. mid stop bit.
//   Back-to-back: FSM is in IDLE for the second half of the stop bit, so a
//     start bit following immediately is detected; no bytes lost.
//   Stop bit low with line held low (break): Frame_err once, then IDLE sees
//     rx_s==0 and re-enters START; each full break frame yields one more
//     Frame_err. No lock-up.
//   Reset mid-frame: immediate return to reset values; partial byte dropped.
//   No input buffering: consumer must take Dout within one byte time.
// TESTING (defaults, CLKS_PER_BIT=10, bit time 8680 ns)
//   1. Send 8'h55, 8N1 -> one Valid pulse ~97 CLK after start edge,
//      Dout=8'h55, Frame_err stays 0, Busy high start..stop centre.
//   2. Send 8'hA3 then 8'h0F with no idle gap -> two Valid pulses 10 bit
//      times apart, Dout=8'hA3 then 8'h0F.
//   3. Rxd low for 3 CLK then high -> Busy pulses briefly, no Valid,
//      no Frame_err, FSM back in IDLE before bit centre +1.
//   4. Send 8'h3C with stop bit driven 0 -> Frame_err 1-cycle pulse, no
//      Valid, Dout keeps previous value (8'h0F after test 2).
//   5. RST low during bit 4 of 8'hFF, release, send 8'h81 -> outputs 0
//      during reset, then exactly one Valid with Dout=8'h81.
//   6. Loopback from the UART transmitter at same CLK_FREQ, bytes
//      8'h01 and 8'h02 -> Dout matches each, no Frame_err.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: two-flop input synchroniser, start-bit qualification at
// half a bit time, LSB-first data capture at bit centre and stop-bit check.
module uart_rx_sampler #(
    parameter int CLK_FREQ  = 1_152_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rxd,
    output logic [7:0] Dout,
    output logic       Valid,
    output logic       Frame_err,
    output logic       Busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchroniser flops reset to the idle line level so release of reset
    // never looks like a start edge.
    logic rx_meta_reg;
    logic rx_s_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= Rxd;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       dout_reg, dout_next;
    logic             valid_reg, valid_next;
    logic             ferr_reg, ferr_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
            dout_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            dout_reg    <= dout_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        dout_next    = dout_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                bit_idx_next = 3'd0;
                if (!rx_s_reg) begin
                    state_next = START;
                end
            end

            START: begin
                clk_cnt_next = clk_cnt_reg + 1'b1;
                if (clk_cnt_reg == HALF_LAST) begin
                    clk_cnt_next = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_next   = rx_s_reg ? IDLE : DATA;
                end
            end

            DATA: begin
                clk_cnt_next = clk_cnt_reg + 1'b1;
                if (clk_cnt_reg == FULL_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {rx_s_reg, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = 3'd0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end

            STOP: begin
                clk_cnt_next = clk_cnt_reg + 1'b1;
                if (clk_cnt_reg == FULL_LAST) begin
                    // Leaving at mid stop bit lets a back-to-back start be seen.
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                    if (rx_s_reg) begin
                        dout_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
                bit_idx_next = 3'd0;
            end
        endcase
    end

    assign Dout      = dout_reg;
    assign Valid     = valid_reg;
    assign Frame_err = ferr_reg;
    assign Busy      = (state_reg != IDLE);

endmodule
